// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops scan bytes from the PS/2 receiver FIFO one at a time, decodes the F0/E0
// prefixes, tracks the single held key and reports make/break/repeat events plus a press count.
module ps2_key_ctrl #(
    parameter int CNT_W       = 8,
    parameter int PFX_TIMEOUT = 100000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_overflow,
    output logic             rx_nextdata_n,
    input  logic             clr,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             key_event,
    output logic             key_make,
    output logic             key_repeat,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int               TMO_W    = (PFX_TIMEOUT > 0) ? $clog2(PFX_TIMEOUT + 1) : 1;
    localparam logic             TMO_EN   = (PFX_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = (PFX_TIMEOUT > 0) ? TMO_W'(PFX_TIMEOUT - 1) : {TMO_W{1'b0}};

    // Keyboard housekeeping bytes that carry no key information.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF: is_ignored = 1'b1;
            default:                                         is_ignored = 1'b0;
        endcase
    endfunction

    logic [1:0]       state_q,      state_d;
    logic [7:0]       byte_q,       byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       key_code_q,   key_code_d;
    logic             key_ext_q,    key_ext_d;
    logic             key_down_q,   key_down_d;
    logic             key_event_q,  key_event_d;
    logic             key_make_q,   key_make_d;
    logic             key_repeat_q, key_repeat_d;
    logic [CNT_W-1:0] press_cnt_q,  press_cnt_d;
    logic             ovf_q,        ovf_d;
    logic             brk_q,        brk_d;
    logic             ext_q,        ext_d;
    logic [8:0]       held_q,       held_d;
    logic [TMO_W-1:0] tmo_q,        tmo_d;
    logic             held_match_s;

    assign held_match_s = (held_q == {ext_q, byte_q});

    // Next-state logic: pop sequencer, byte decode, prefix timeout and counters.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_down_d   = key_down_q;
        key_event_d  = 1'b0;
        key_make_d   = key_make_q;
        key_repeat_d = key_repeat_q;
        press_cnt_d  = press_cnt_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        held_d       = held_q;
        tmo_d        = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_ready) begin
                    state_d = ST_POP;
                    byte_d  = rx_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP:  state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        nextdata_n_d = (state_d != ST_POP);

        if (state_q == ST_POP) begin
            tmo_d = {TMO_W{1'b0}};
            if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (is_ignored(byte_q)) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                key_event_d = 1'b1;
                key_code_d  = byte_q;
                key_ext_d   = ext_q;
                brk_d       = 1'b0;
                ext_d       = 1'b0;
                if (brk_q) begin
                    key_make_d   = 1'b0;
                    key_repeat_d = 1'b0;
                    // A break for some other key leaves the held key down.
                    if (held_match_s) begin
                        key_down_d = 1'b0;
                    end else begin
                        key_down_d = key_down_q;
                    end
                end else if (key_down_q && held_match_s) begin
                    key_make_d   = 1'b1;
                    key_repeat_d = 1'b1;
                end else begin
                    key_make_d   = 1'b1;
                    key_repeat_d = 1'b0;
                    held_d       = {ext_q, byte_q};
                    key_down_d   = 1'b1;
                    press_cnt_d  = press_cnt_q + CNT_W'(1);
                end
            end
        end else if (TMO_EN && (brk_q || ext_q)) begin
            if (tmo_q == TMO_LAST) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                tmo_d = {TMO_W{1'b0}};
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end

        // Clear takes priority over a same-cycle press or overflow.
        if (clr) begin
            press_cnt_d = {CNT_W{1'b0}};
            ovf_d       = 1'b0;
        end else begin
            ovf_d = ovf_q | rx_overflow;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_down_q   <= 1'b0;
            key_event_q  <= 1'b0;
            key_make_q   <= 1'b0;
            key_repeat_q <= 1'b0;
            press_cnt_q  <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            held_q       <= 9'h000;
            tmo_q        <= {TMO_W{1'b0}};
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_down_q   <= key_down_d;
            key_event_q  <= key_event_d;
            key_make_q   <= key_make_d;
            key_repeat_q <= key_repeat_d;
            press_cnt_q  <= press_cnt_d;
            ovf_q        <= ovf_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            held_q       <= held_d;
            tmo_q        <= tmo_d;
        end
    end

    assign rx_nextdata_n = nextdata_n_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_down      = key_down_q;
    assign key_event     = key_event_q;
    assign key_make      = key_make_q;
    assign key_repeat    = key_repeat_q;
    assign press_cnt     = press_cnt_q;
    assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: FIFO-style receiver model, event scoreboard driven by a key-level
// reference model, a directed vector table and randomized byte streams.
module tb_ps2_key_ctrl;
    localparam int TMO = 20;

    logic       clock;
    logic       resetn;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_overflow;
    logic       rx_nextdata_n;
    logic       clr;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       key_event;
    logic       key_make;
    logic       key_repeat;
    logic [7:0] press_cnt;
    logic       ovf_sticky;

    ps2_key_ctrl #(.CNT_W(8), .PFX_TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n), .clr(clr),
        .key_code(key_code), .key_ext(key_ext), .key_down(key_down), .key_event(key_event),
        .key_make(key_make), .key_repeat(key_repeat), .press_cnt(press_cnt), .ovf_sticky(ovf_sticky)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       make;
        logic       rep;
        logic       down;
        logic [7:0] cnt;
    } ev_t;

    typedef struct packed {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       make;
        logic       rep;
        logic       down;
        logic [7:0] cnt;
    } vec_t;

    int         chk = 0;
    int         err = 0;
    int         ev_cnt = 0;
    int         cyc = 0;
    logic [7:0] rxq[$];
    ev_t        expq[$];
    int         pop_log[$];
    logic       clr_req = 1'b0;
    ev_t        mon_e;
    logic       ev_prev = 1'b0;
    logic       low_prev = 1'b0;
    logic [7:0] popped;

    // Key-level reference model state.
    logic       m_brk, m_ext, m_down;
    logic [8:0] m_held;
    logic [7:0] m_cnt;
    int         m_pfx_cyc;

    vec_t vec [0:18];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int now, input logic do_clr);
        ev_t e;
        logic has_ev;
        has_ev = 1'b0;
        if ((m_brk || m_ext) && (now - m_pfx_cyc > TMO)) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            m_pfx_cyc = now;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
            m_pfx_cyc = now;
        end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1, 8'h00, 8'hFF}) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            has_ev = 1'b1;
            e.code = b;
            e.ext  = m_ext;
            if (m_brk) begin
                e.make = 1'b0;
                e.rep  = 1'b0;
                if (m_held == {m_ext, b}) m_down = 1'b0;
            end else if (m_down && m_held == {m_ext, b}) begin
                e.make = 1'b1;
                e.rep  = 1'b1;
            end else begin
                e.make = 1'b1;
                e.rep  = 1'b0;
                m_held = {m_ext, b};
                m_down = 1'b1;
                m_cnt  = m_cnt + 8'd1;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (do_clr) m_cnt = 8'd0;
        if (has_ev) begin
            e.down = m_down;
            e.cnt  = m_cnt;
            expq.push_back(e);
        end
    endtask

    // Receiver FIFO model plus event/pop monitor, all on the falling edge.
    initial begin
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        clr      = 1'b0;
        m_brk = 1'b0; m_ext = 1'b0; m_down = 1'b0;
        m_held = 9'h000; m_cnt = 8'd0; m_pfx_cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (key_event === 1'b1) begin
                check("event_pulse", {31'd0, ev_prev}, 32'd0);
                if (expq.size() == 0) begin
                    check("unexpected_event", {24'd0, key_code}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = expq.pop_front();
                    check("ev_code", {24'd0, key_code}, {24'd0, mon_e.code});
                    check("ev_ext", {31'd0, key_ext}, {31'd0, mon_e.ext});
                    check("ev_make", {31'd0, key_make}, {31'd0, mon_e.make});
                    check("ev_repeat", {31'd0, key_repeat}, {31'd0, mon_e.rep});
                    check("ev_down", {31'd0, key_down}, {31'd0, mon_e.down});
                    check("ev_cnt", {24'd0, press_cnt}, {24'd0, mon_e.cnt});
                end
                ev_cnt++;
            end
            ev_prev = (key_event === 1'b1);
            clr = 1'b0;
            if (rx_nextdata_n === 1'b0) begin
                check("pop_single", {31'd0, low_prev}, 32'd0);
                check("pop_nonempty", {31'd0, (rxq.size() > 0)}, 32'd1);
                pop_log.push_back(cyc);
                if (rxq.size() > 0) begin
                    popped = rxq.pop_front();
                    clr = clr_req;
                    clr_req = 1'b0;
                    model_byte(popped, cyc, clr);
                end
            end
            low_prev = (rx_nextdata_n === 1'b0);
            rx_ready = (rxq.size() > 0);
            rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rxq.size() != 0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        check("drain", rxq.size(), 32'd0);
        rxq.delete();
        repeat (4) @(posedge clock);
    endtask

    initial begin
        int ev0;
        logic [7:0] b;
        logic [7:0] pool [0:7];

        vec[0]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vec[1]  = '{8'hF0, 1'b0, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vec[2]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vec[3]  = '{8'h1B, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
        vec[4]  = '{8'h1B, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
        vec[5]  = '{8'h1B, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
        vec[6]  = '{8'hF0, 1'b0, 8'h1B, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
        vec[7]  = '{8'h1B, 1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vec[8]  = '{8'hE0, 1'b0, 8'h1B, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vec[9]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vec[10] = '{8'hE0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vec[11] = '{8'hF0, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vec[12] = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        vec[13] = '{8'hE0, 1'b0, 8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        vec[14] = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4};
        vec[15] = '{8'h75, 1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
        vec[16] = '{8'hF0, 1'b0, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
        vec[17] = '{8'hAA, 1'b0, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
        vec[18] = '{8'h75, 1'b1, 8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5};

        pool[0] = 8'hF0; pool[1] = 8'hE0; pool[2] = 8'h1C; pool[3] = 8'h1B;
        pool[4] = 8'h75; pool[5] = 8'h2A; pool[6] = 8'hAA; pool[7] = 8'h00;

        resetn = 1'b0;
        rx_overflow = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_nextdata_n", {31'd0, rx_nextdata_n}, 32'd1);
        check("rst_outputs", {key_code, key_ext, key_down, key_event, key_make, key_repeat, press_cnt, ovf_sticky},
              32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 19; i++) begin
            ev0 = ev_cnt;
            push(vec[i].b);
            drain();
            check("tbl_event", ev_cnt - ev0, {31'd0, vec[i].ev});
            check("tbl_code", {24'd0, key_code}, {24'd0, vec[i].code});
            check("tbl_flags", {28'd0, key_ext, key_make, key_repeat, key_down},
                  {28'd0, vec[i].ext, vec[i].make, vec[i].rep, vec[i].down});
            check("tbl_cnt", {24'd0, press_cnt}, {24'd0, vec[i].cnt});
        end

        // Four queued bytes with rx_ready held high: single-cycle pops, 3 cycles apart.
        pop_log.delete();
        push(8'h00); push(8'hFF); push(8'hAA); push(8'hFA);
        drain();
        check("thru_pops", pop_log.size(), 32'd4);
        for (int i = 1; i < pop_log.size(); i++) check("thru_spacing", pop_log[i] - pop_log[i-1], 32'd3);

        // Expired break prefix: 2A becomes a make; fresh prefix followed promptly is a break.
        push(8'hF0);
        drain();
        repeat (30) @(posedge clock);
        push(8'h2A);
        drain();
        check("tmo_make", {30'd0, key_make, key_repeat}, 32'd2);
        check("tmo_cnt", {24'd0, press_cnt}, 32'd6);
        push(8'hF0);
        drain();
        push(8'h2A);
        drain();
        check("pfx_live_break", {29'd0, key_make, key_repeat, key_down}, 32'd0);

        @(negedge clock) rx_overflow = 1'b1;
        @(negedge clock) rx_overflow = 1'b0;
        @(negedge clock);
        check("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
        clr_req = 1'b1;
        push(8'h00);
        drain();
        check("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
        check("clr_cnt", {24'd0, press_cnt}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            b = pool[$urandom_range(0, 7)];
            push(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 30)) @(posedge clock);
        end
        drain();
        check("rand_cnt", {24'd0, press_cnt}, {24'd0, m_cnt});
        check("rand_down", {31'd0, key_down}, {31'd0, m_down});

        push(8'h00);
        drain();
        for (int i = 0; i < 300 && m_cnt != 8'hFF; i++) begin
            push((m_held == 9'h015) ? 8'h16 : 8'h15);
            drain();
        end
        check("cnt_max", {24'd0, press_cnt}, 32'hFF);
        push((m_held == 9'h015) ? 8'h16 : 8'h15);
        drain();
        check("cnt_wrap", {24'd0, press_cnt}, 32'h00);
        push((m_held == 9'h015) ? 8'h16 : 8'h15);
        drain();
        check("cnt_before_clr", {24'd0, press_cnt}, 32'h01);
        clr_req = 1'b1;
        push((m_held == 9'h015) ? 8'h16 : 8'h15);
        drain();
        check("clr_vs_press", {24'd0, press_cnt}, 32'h00);
        check("exp_empty", expq.size(), 32'd0);

        // Reset in the middle of a pop must release rx_nextdata_n immediately.
        push(8'h1C);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #2;
            if (rx_nextdata_n === 1'b0) break;
        end
        check("pop_seen", {31'd0, rx_nextdata_n}, 32'd0);
        resetn = 1'b0;
        #1;
        check("rst_mid_pop", {31'd0, rx_nextdata_n}, 32'd1);
        check("rst_mid_outputs", {key_down, key_event, press_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
